// File: rtl/dmem_responder.sv
// Fixed-latency word-addressed data memory responder with an IDLE/WAIT/DONE handshake.
// Define DMEM_RANGE_CHECK_EN to flag out-of-range addresses on err instead of wrapping them.
module dmem_responder #(
    parameter int XLEN    = 32,
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [XLEN-1:0] address,
    input  logic            mem_load,
    input  logic            mem_store,
    input  logic [XLEN-1:0] store_data,
    output logic [XLEN-1:0] load_data,
    output logic            ready,
    output logic            busy,
    output logic            err
);
    localparam int AW = $clog2(DEPTH);

`ifdef DMEM_RANGE_CHECK_EN
    localparam logic RANGE_CHECK = 1'b1;
`else
    localparam logic RANGE_CHECK = 1'b0;
`endif

    // Handshake: mem_load/mem_store are held by the initiator until ready; ready is a
    // one-cycle completion pulse; dropping both requests while in WAIT aborts the access.
    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2} state_t;

    state_t          state;
    state_t          state_next;
    logic [3:0]      count;
    logic [AW-1:0]   idx_q;
    logic            load_q;
    logic            store_q;
    logic            oor_q;
    logic [XLEN-1:0] data_q;
    logic [XLEN-1:0] mem [DEPTH];

    logic            req;
    logic [AW-1:0]   addr_idx;
    logic            addr_oor;
    logic [AW-1:0]   rd_idx;
    logic            rd_load;
    logic            rd_oor;
    logic [XLEN-1:0] addr_unused;

    assign req         = mem_load | mem_store;
    assign addr_idx    = address[AW+1:2];
    assign addr_oor    = RANGE_CHECK && ((address >> (AW + 2)) != '0);
    assign addr_unused = address;

    // With LATENCY=1 DONE is entered straight from IDLE, before anything is latched.
    assign rd_idx  = (state == IDLE) ? addr_idx : idx_q;
    assign rd_load = (state == IDLE) ? mem_load : load_q;
    assign rd_oor  = (state == IDLE) ? addr_oor : oor_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req) state_next = (LATENCY == 1) ? DONE : WAIT;
            end
            WAIT: begin
                if (!req)               state_next = IDLE;
                else if (count == 4'd1) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ready = (state == DONE);
        busy  = (state != IDLE);
        err   = RANGE_CHECK && (state == DONE) && oor_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count     <= '0;
            idx_q     <= '0;
            load_q    <= 1'b0;
            store_q   <= 1'b0;
            oor_q     <= 1'b0;
            data_q    <= '0;
            load_data <= '0;
        end else begin
            if (state == IDLE && req) begin
                idx_q   <= addr_idx;
                load_q  <= mem_load;
                store_q <= mem_store;
                oor_q   <= addr_oor;
                data_q  <= store_data;
                count   <= 4'(LATENCY - 1);
            end else if (state == WAIT) begin
                count <= req ? count - 4'd1 : 4'd0;
            end
            // Read happens on entry to DONE, one edge before any store commits.
            if (state != DONE && state_next == DONE) begin
                if (rd_oor)       load_data <= '0;
                else if (rd_load) load_data <= mem[rd_idx];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && state == DONE && store_q && !oor_q) begin
            mem[idx_q] <= data_q;
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Randomised scoreboard bench for dmem_responder: a word-array model predicts every completion.
// Honours DMEM_RANGE_CHECK_EN the same way as the design.
module tb_dmem_responder;
    localparam int XLEN  = 32;
    localparam int DEPTH = 1024;
    localparam int LAT   = 2;
    localparam int AW    = 10;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic [XLEN-1:0] address = '0;
    logic            mem_load = 1'b0;
    logic            mem_store = 1'b0;
    logic [XLEN-1:0] store_data = '0;
    logic [XLEN-1:0] load_data;
    logic            ready;
    logic            busy;
    logic            err;

    dmem_responder #(.XLEN(XLEN), .DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clock(clock), .reset(reset), .address(address), .mem_load(mem_load),
        .mem_store(mem_store), .store_data(store_data), .load_data(load_data),
        .ready(ready), .busy(busy), .err(err)
    );

    always #5 clock = ~clock;

    int cycle = 0;
    always @(posedge clock) cycle <= cycle + 1;

    int checks = 0;
    int errors = 0;

    logic [XLEN-1:0] exp_q[$];
    logic            exp_err_q[$];
    int              exp_acc_q[$];

    logic [XLEN-1:0] ref_mem [DEPTH];
    logic [XLEN-1:0] last_ld = '0;

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Monitor: every ready pulse must match the oldest outstanding prediction.
    always @(negedge clock) begin
        if (!reset && ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready: got ready=1 expected no completion (cycle %0d)", cycle);
            end else begin
                logic [XLEN-1:0] e_data;
                logic            e_err;
                int              e_acc;
                e_data = exp_q.pop_front();
                e_err  = exp_err_q.pop_front();
                e_acc  = exp_acc_q.pop_front();
                chk("load_data", load_data, e_data);
                chk("err", 32'(err), 32'(e_err));
                chk("latency", 32'(cycle + 1 - e_acc), 32'(LAT));
            end
        end
    end

    task automatic do_req(input logic ld, input logic st, input logic [XLEN-1:0] addr,
                          input logic [XLEN-1:0] data, input bit abort);
        logic [AW-1:0]   idx;
        logic            oor;
        logic [XLEN-1:0] e;
        int              n;
        @(negedge clock);
        mem_load   = ld;
        mem_store  = st;
        address    = addr;
        store_data = data;
        idx = addr[AW+1:2];
        oor = 1'b0;
`ifdef DMEM_RANGE_CHECK_EN
        oor = (addr >= 32'(DEPTH * 4));
`endif
        if (!abort) begin
            e = oor ? '0 : (ld ? ref_mem[idx] : last_ld);
            if (st && !oor) ref_mem[idx] = data;
            last_ld = e;
            exp_q.push_back(e);
            exp_err_q.push_back(oor);
            exp_acc_q.push_back(cycle + 1);
        end
        @(negedge clock);
        chk("busy_after_accept", 32'(busy), 32'd1);
        if (abort) begin
            mem_load  = 1'b0;
            mem_store = 1'b0;
            @(negedge clock);
            chk("abort_ready", 32'(ready), 32'd0);
            chk("abort_busy", 32'(busy), 32'd0);
            chk("abort_hold", load_data, last_ld);
        end else begin
            n = 0;
            while (!ready && n < 20) begin
                @(negedge clock);
                n++;
            end
            if (!ready) begin
                checks++;
                errors++;
                $display("FAIL ready_timeout: got no ready expected ready within 20 cycles (cycle %0d)", cycle);
            end else begin
                chk("busy_done", 32'(busy), 32'd1);
            end
            mem_load  = 1'b0;
            mem_store = 1'b0;
        end
    endtask

    task automatic reset_during_wait(input logic [XLEN-1:0] addr, input logic [XLEN-1:0] data);
        @(negedge clock);
        mem_load   = 1'b0;
        mem_store  = 1'b1;
        address    = addr;
        store_data = data;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_load_data", load_data, '0);
        last_ld   = '0;
        reset     = 1'b0;
        mem_store = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clock);
        chk("init_ready", 32'(ready), 32'd0);
        chk("init_busy", 32'(busy), 32'd0);
        chk("init_err", 32'(err), 32'd0);
        chk("init_load_data", load_data, '0);
        reset = 1'b0;

        for (int w = 0; w < 64; w++) do_req(1'b0, 1'b1, 32'(w * 4), $urandom, 1'b0);

        do_req(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
        do_req(1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
        do_req(1'b1, 1'b0, 32'h13, 32'h0, 1'b0);
        do_req(1'b0, 1'b1, 32'h20, 32'h11111111, 1'b1);
        do_req(1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
        reset_during_wait(32'h30, 32'h22222222);
        do_req(1'b1, 1'b0, 32'h30, 32'h0, 1'b0);
        do_req(1'b0, 1'b1, 32'h40, 32'hA5A5A5A5, 1'b0);
        do_req(1'b1, 1'b1, 32'h40, 32'h5A5A5A5A, 1'b0);
        do_req(1'b1, 1'b0, 32'h40, 32'h0, 1'b0);
        do_req(1'b1, 1'b0, 32'h1000, 32'h0, 1'b0);

        for (int i = 0; i < 200; i++) begin
            int              op;
            logic [XLEN-1:0] a;
            op = $urandom_range(0, 2);
            a  = 32'($urandom_range(0, 63) * 4 + $urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) a = a | (32'($urandom_range(1, 15)) << 12);
            do_req(op != 1, op != 0, a, $urandom, $urandom_range(0, 7) == 0);
        end

        repeat (5) @(negedge clock);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter XLEN, default 32, data and address width in bits.
REQ-002 SHALL have parameter DEPTH, default 1024, number of XLEN-bit words stored (power of two).
REQ-003 SHALL have parameter LATENCY, default 2, cycles from request acceptance to ready (legal range 1..15).
REQ-004 SHALL have port clock, input, 1, the single clock; all state updates on the rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port address, input, XLEN, byte address of the data access.
REQ-007 SHALL have port mem_load, input, 1, load request, held by the initiator until ready.
REQ-008 SHALL have port mem_store, input, 1, store request, held by the initiator until ready.
REQ-009 SHALL have port store_data, input, XLEN, full word to write; byte merging is done by the initiator.
REQ-010 SHALL have port load_data, output, XLEN, word read at the completed request.
REQ-011 SHALL have port ready, output, 1, one-cycle completion pulse.
REQ-012 SHALL have port busy, output, 1, high while a request is in flight.
REQ-013 SHALL have port err, output, 1, range-error flag (see Configuration).

Function
REQ-014 SHALL form the word index from address[log2(DEPTH)+1:2]; address[1:0] is ignored.
REQ-015 SHALL implement FSM states IDLE, WAIT, DONE.
REQ-016 IDLE: when mem_load or mem_store is high, SHALL latch the index, the operation and store_data, load the counter with LATENCY-1, and go to WAIT (if LATENCY=1, go directly to DONE).
REQ-017 WAIT: SHALL decrement the counter each cycle and go to DONE when the counter is 0.
REQ-018 On entering DONE, load_data SHALL hold the word at the latched index, read before any write in the same operation.
REQ-019 In DONE, SHALL assert ready for exactly one cycle, commit the store to the array on that edge, and return to IDLE.
REQ-020 Request-to-ready latency SHALL be exactly LATENCY cycles, counting from the accept edge to the ready-high cycle.
REQ-021 busy SHALL be high in WAIT and DONE, and low in IDLE.
REQ-022 If mem_load and mem_store are both high, SHALL perform a store and return the old word on load_data.
REQ-023 If both requests drop while in WAIT, SHALL abort to IDLE with no write, no ready pulse, and load_data unchanged.
REQ-024 Request inputs SHALL be ignored in WAIT and DONE, apart from the abort check in REQ-023.
REQ-025 The earliest next accept SHALL be the cycle after DONE; back-to-back throughput is one request per LATENCY+1 cycles.
REQ-026 load_data SHALL hold its value between completions and SHALL NOT change on a store-only completion unless REQ-022 applies.

Reset
REQ-027 On reset high at a clock edge, SHALL enter IDLE with counter=0, ready=0, busy=0, err=0 and load_data=0.
REQ-028 Reset during WAIT or DONE SHALL discard the pending operation without committing the store.
REQ-029 Array contents SHALL NOT be cleared by reset.

Configuration
REQ-030 With macro DMEM_RANGE_CHECK_EN defined, an address >= DEPTH*4 SHALL set err for the DONE cycle only, suppress the store, and return load_data=0.
REQ-031 Without DMEM_RANGE_CHECK_EN, err SHALL be tied 0, and out-of-range addresses SHALL wrap modulo DEPTH (upper bits ignored).

Verification
REQ-032 LATENCY=2: store 0xDEADBEEF to 0x10, then load 0x10 -> ready pulses 2 cycles after each accept, busy high 2 cycles each, load_data=0xDEADBEEF.
REQ-033 Load 0x13 after REQ-032 -> load_data=0xDEADBEEF (low bits ignored).
REQ-034 Store 0x11111111 to 0x20, then drop mem_store in WAIT -> no ready pulse; a later load of 0x20 returns the prior contents.
REQ-035 Assert reset during WAIT of a store 0x22222222 to 0x30 -> IDLE next cycle, outputs 0; a load of 0x30 returns the old value.
REQ-036 Load and store high together at 0x40 with old word 0xA5A5A5A5 and store_data 0x5A5A5A5A -> load_data=0xA5A5A5A5; a subsequent load returns 0x5A5A5A5A.
REQ-037 DMEM_RANGE_CHECK_EN defined, DEPTH=1024, load 0x1000 -> err=1 with ready, load_data=0; undefined -> err=0, load_data equals word 0.
